core_sequencer: RTL
===================

# core_sequencer

Run controller for the 8-bit single-cycle core. It loads a program into instruction memory through a valid/ready stream, then holds the core in reset for a fixed number of cycles. It releases the core, counts executed cycles and stops the run on a HALT opcode or a cycle-budget timeout. It sits between the test/host side and the core and instruction memory, and gates core data-memory writes to the RUN window.

## Interface

Parameters:
- IMEM_DEPTH, 256: instruction-memory words; load address width is 8 bits.
- HALT_OP, 6'b111111: opcode (inst[8:3]) that terminates a run.
- RST_CYCLES, 2: cycles core_rst is held before RUN (≥1).
- MAX_CYCLES, 16'hFFFF: RUN cycle budget before timeout (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- load  in  1  qualifies start: 1 = load then run, 0 = rerun resident program.
- abort  in  1  return to IDLE from any state.
- ld_valid  in  1  program word available.
- ld_data  in  9  program word.
- ld_last  in  1  marks final word of the program.
- ld_ready  out  1  sequencer accepts a word this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  8  instruction-memory write address.
- imem_wdata  out  9  instruction-memory write data (= ld_data).
- inst  in  9  instruction currently fetched by the core.
- core_memwrite  in  1  core MemWrite.
- dmem_we  out  1  gated data-memory write enable.
- core_rst  out  1  reset to the core.
- busy  out  1  state ≠ IDLE and ≠ DONE.
- done  out  1  run finished; held until next start/abort/rst.
- timeout  out  1  qualifies done: run ended by budget, not HALT.
- cycle_count  out  16  RUN cycles of the current/last run.

## Operation

- States: IDLE, LOAD, CRST, RUN, DONE.
- IDLE: if start is asserted, go to LOAD when load=1, otherwise go to CRST. On start, clear done, timeout, cycle_count and the load address.
- LOAD: ld_ready=1. imem_we = ld_valid & ld_ready. imem_waddr = load address register, which starts at 0 and increments per accepted word.
  - Go to CRST when the accepted word has ld_last=1, or when address IMEM_DEPTH-1 is written; the latter is a forced end.
  - No transfer occurs when ld_valid=0.
- CRST: core_rst=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: core_rst=0. cycle_count increments every RUN cycle, including the terminating cycle.
  - If inst[8:3]==HALT_OP, go to DONE with timeout=0.
  - Otherwise, if the incremented count equals MAX_CYCLES, go to DONE with timeout=1.
  - HALT has priority over timeout in the same cycle.
- DONE: core_rst=1 and done=1. start is accepted exactly as in IDLE.
- abort, in any state: go to IDLE next cycle with core_rst=1, done=0 and timeout=0. cycle_count is retained. abort beats start and all other transitions.
- dmem_we = core_memwrite & (state==RUN); it is forced to 0 in every other state.
- Outputs are registered or decoded from registered state. imem_we and dmem_we are combinational from the current state and their inputs.

## Timing

- Reset values: state=IDLE, core_rst=1, ld_ready=0, imem_we=0, dmem_we=0, busy=0, done=0, timeout=0, cycle_count=0, load address=0.
- rst asserted mid-run forces the reset values on the next edge. The resident imem contents are untouched.
- start at edge N gives busy=1 from N+1.
- In LOAD, each accepted word is written on the same edge it is accepted. The last word at edge M gives CRST during M+1 … M+RST_CYCLES, and RUN first at M+RST_CYCLES+1.
- A load of K words takes K accepting cycles plus any ld_valid gaps.
- The first RUN cycle sees the core at pc=0. A HALT at address 0 ends the run with cycle_count=1.
- done rises the cycle after the terminating RUN cycle.
- start while busy is ignored. start and abort on the same cycle: abort wins.
- ld_valid outside LOAD is ignored: no write, and ld_ready=0.

## Test plan

- Reset: hold rst for 3 cycles, then check core_rst=1, busy=0, done=0, cycle_count=0, ld_ready=0. Release rst and confirm outputs are stable with no start.
- Load and halt: start with load=1, then stream 4 words with the last = {HALT_OP,3'b0}, ld_last on word 3.
  - imem_waddr must be 0..3 and ld_ready must drop the cycle after word 3.
  - core_rst must be high for 2 cycles, followed by exactly 4 RUN cycles.
  - Final state: done=1, timeout=0, cycle_count=4.
- Backpressure gaps: insert ld_valid=0 cycles between words. The gap cycles must produce no imem_we and no address increment. Addresses stay contiguous.
- Timeout: with MAX_CYCLES=10, run a program with no HALT. Expect done=1, timeout=1 and cycle_count=10 exactly 10 cycles after RUN entry; dmem_we=0 thereafter.
- Rerun and HALT/timeout tie: after DONE, start with load=0 and skip LOAD. Put HALT on the 10th RUN cycle with MAX_CYCLES=10; expect timeout=0 and cycle_count=10.
- Abort and write gating: assert abort in RUN while core_memwrite=1.
  - dmem_we=1 that cycle, then IDLE next cycle with core_rst=1, dmem_we=0 and done=0.
  - start together with abort must be ignored.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Program-load stream into the sequencer and the instruction-memory write port it drives.
// A word transfers on a rising edge where ld_valid && ld_ready; ld_data/ld_last are meaningful only while ld_valid is high.
interface core_sequencer_if;
  logic       ld_valid;
  logic [8:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       imem_we;
  logic [7:0] imem_waddr;
  logic [8:0] imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/core_sequencer.sv
// Run controller for the 8-bit core: loads imem, holds core reset, runs until HALT or budget timeout.
// fsm_state exposes the current FSM state encoding for observation.
module core_sequencer #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [5:0]  HALT_OP    = 6'b111111,
  parameter int          RST_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load,
  input  logic             abort,
  core_sequencer_if.slave  ld,
  input  logic [8:0]       inst,
  input  logic             core_memwrite,
  output logic             dmem_we,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [15:0]      cycle_count,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CRST = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int        CW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CRST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [7:0]    LAST_ADDR = 8'(IMEM_DEPTH - 1);

  state_t        state_q, state_d;
  logic [7:0]    addr_q;
  logic [15:0]   cycle_q;
  logic [15:0]   cycle_inc;
  logic [CW-1:0] crst_q;
  logic          timeout_q;

  logic run_start;
  logic word_acc;
  logic run_tick;
  logic to_hit;

  // Low opcode-operand bits never influence sequencing.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[2:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    word_acc  = 1'b0;
    run_tick  = 1'b0;
    to_hit    = 1'b0;
    cycle_inc = cycle_q + 16'd1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          run_start = 1'b1;
          state_d   = load ? S_LOAD : S_CRST;
        end
      end
      S_LOAD: begin
        if (ld.ld_valid) begin
          word_acc = 1'b1;
          if (ld.ld_last || (addr_q == LAST_ADDR)) state_d = S_CRST;
        end
      end
      S_CRST: begin
        if (crst_q == CRST_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        run_tick = 1'b1;
        // HALT wins when it lands on the last budgeted cycle.
        if (inst[8:3] == HALT_OP) begin
          state_d = S_DONE;
        end else if (cycle_inc == MAX_CYCLES) begin
          state_d = S_DONE;
          to_hit  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      run_start = 1'b0;
      word_acc  = 1'b0;
      run_tick  = 1'b0;
      to_hit    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 8'd0;
      cycle_q   <= 16'd0;
      timeout_q <= 1'b0;
      crst_q    <= '0;
    end else begin
      if (abort) begin
        timeout_q <= 1'b0;
      end else if (run_start) begin
        addr_q    <= 8'd0;
        cycle_q   <= 16'd0;
        timeout_q <= 1'b0;
      end
      if (word_acc) addr_q <= addr_q + 8'd1;
      if (run_tick) begin
        cycle_q <= cycle_inc;
        if (to_hit) timeout_q <= 1'b1;
      end
      // Counter idles at zero so every CRST entry starts a fresh hold.
      if (state_q == S_CRST) crst_q <= crst_q + CW'(1);
      else                   crst_q <= '0;
    end
  end

  assign ld.ld_ready   = (state_q == S_LOAD);
  assign ld.imem_we    = ld.ld_valid & ld.ld_ready;
  assign ld.imem_waddr = addr_q;
  assign ld.imem_wdata = ld.ld_data;

  assign dmem_we     = core_memwrite & (state_q == S_RUN);
  assign core_rst    = (state_q != S_RUN);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign fsm_state   = state_q;

endmodule
